alu_issue_stage: RTL and testbench

- Operand issue and result capture stage that wraps the team's combinational 32-bit ALU (F[2:0], A, B -> Y, zero).
- Accepts operations from the upstream datapath over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head onto the ALU inputs, registers the ALU result, and presents it downstream with valid/ready backpressure.
- Also counts completed results and flags unsupported function codes.

---
 rtl/alu_issue_stage.sv | 156 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage around the combinational 32-bit ALU: buffers operations in a small FIFO,
// feeds the head to the ALU and holds the result in a valid/ready output register.
module alu_issue_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_f,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [2:0]       alu_f,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_y,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam logic [2:0] F_UNUSED = 3'b011;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]        r_mem_f [DEPTH];
  logic [31:0]       r_mem_a [DEPTH];
  logic [31:0]       r_mem_b [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_count;

  logic [31:0]       r_out_y;
  logic              r_out_zero;
  logic              r_out_illegal;
  logic [CNT_W-1:0]  r_op_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_issue;
  logic w_out_hs;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FCNT_W'(DEPTH));
  // in_ready comes from the FIFO count only, so a full FIFO refuses even on a same-cycle pop.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    out_valid    = (r_state == S_FULL);
    w_out_hs     = (r_state == S_FULL) && out_ready;
    case (r_state)
      S_EMPTY: begin
        if (!w_empty) begin
          w_issue      = 1'b1;
          w_state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (out_ready) begin
          if (!w_empty) begin
            w_issue = 1'b1;
          end else begin
            w_state_next = S_EMPTY;
          end
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset: the pointers and count alone define what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
        r_mem_f[gi] <= in_f;
        r_mem_a[gi] <= in_a;
        r_mem_b[gi] <= in_b;
      end
    end
  end

  assign alu_f = w_empty ? 3'b000 : r_mem_f[r_rd_ptr];
  assign alu_a = w_empty ? 32'h0  : r_mem_a[r_rd_ptr];
  assign alu_b = w_empty ? 32'h0  : r_mem_b[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_y       <= '0;
      r_out_zero    <= 1'b0;
      r_out_illegal <= 1'b0;
    end else if (w_issue) begin
      r_out_y       <= alu_y;
      r_out_zero    <= alu_zero;
      r_out_illegal <= (alu_f == F_UNUSED);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_count <= '0;
    end else if (w_out_hs) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign out_y       = r_out_y;
  assign out_zero    = r_out_zero;
  assign out_illegal = r_out_illegal;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: models the ALU, keeps a queue of expected results in push
// order and checks every presented result, the handshake count and directed scenarios.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_f;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  alu_f;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_zero;
  logic        out_illegal;
  logic [7:0]  op_count;

  alu_issue_stage #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f), .in_a(in_a), .in_b(in_b),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_illegal(out_illegal), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_0011;
    endcase
  endfunction

  always_comb begin
    alu_y    = alu_ref(alu_f, alu_a, alu_b);
    alu_zero = (alu_y == 32'h0);
  end

  typedef struct {
    logic [31:0] y;
    logic        z;
    logic        ill;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] exp_count;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // One clock: scoreboard at the falling edge, then count check just after the rising edge.
  task automatic tick();
    res_t r;
    logic hs_in;
    logic hs_out;
    @(negedge clk);
    hs_in  = in_valid && in_ready;
    hs_out = out_valid && out_ready;
    if (out_valid) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("sb_y", out_y, exp_q[0].y);
        chk("sb_zero", 32'(out_zero), 32'(exp_q[0].z));
        chk("sb_illegal", 32'(out_illegal), 32'(exp_q[0].ill));
      end
    end
    if (hs_in) begin
      r.y   = alu_ref(in_f, in_a, in_b);
      r.z   = (r.y == 32'h0);
      r.ill = (in_f == 3'b011);
      exp_q.push_back(r);
    end
    if (hs_out && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      exp_count++;
    end
    @(posedge clk);
    #1;
    chk("op_count", 32'(op_count), 32'(exp_count));
  endtask

  task automatic set_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_f = f;
    in_a = a;
    in_b = b;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_f = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    exp_count = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu_f", 32'(alu_f), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Single add, latency of one cycle after accept
    set_op(3'b010, 32'd5, 32'd7);
    tick();
    in_valid = 1'b0;
    chk("lat_valid_early", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("add_y", out_y, 32'd12);
    chk("add_zero", 32'(out_zero), 32'd0);
    chk("add_illegal", 32'(out_illegal), 32'd0);
    tick();
    chk("add_count", 32'(op_count), 32'd1);

    // Subtract to zero
    set_op(3'b110, 32'h10, 32'h10);
    tick();
    in_valid = 1'b0;
    tick();
    chk("sub_y", out_y, 32'd0);
    chk("sub_zero", 32'(out_zero), 32'd1);
    tick();

    // Backpressure fills the FIFO behind a held result
    out_ready = 1'b0;
    set_op(3'b000, 32'hFF00FF00, 32'h0F0F0F0F);
    chk("bp_ready0", 32'(in_ready), 32'd1);
    tick();
    set_op(3'b001, 32'hFF00FF00, 32'h0F0F0F0F);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    tick();
    set_op(3'b010, 32'd1, 32'd1);
    chk("bp_ready2", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_full", 32'(in_ready), 32'd0);
    chk("bp_hold_y", out_y, 32'h0F000F00);
    tick();
    tick();
    chk("bp_still_y", out_y, 32'h0F000F00);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_or_y", out_y, 32'hFF0FFF0F);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_add_y", out_y, 32'd2);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Unused function code flags only its own result
    set_op(3'b011, 32'd3, 32'd4);
    tick();
    set_op(3'b010, 32'd10, 32'd20);
    tick();
    in_valid = 1'b0;
    chk("ill_flag", 32'(out_illegal), 32'd1);
    tick();
    chk("ill_next_flag", 32'(out_illegal), 32'd0);
    chk("ill_next_y", out_y, 32'd30);
    tick();

    // Asynchronous reset with work queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(3'b010, 32'(i), 32'd100);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(op_count), 32'd0);
    exp_q.delete();
    exp_count = '0;
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("no_stale", 32'(out_valid), 32'd0);
    set_op(3'b001, 32'h00F0, 32'h0F00);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_y", out_y, 32'h0FF0);
    tick();
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    // Sustained stream: op_count wraps and no bubbles appear
    for (int i = 0; i < 256; i++) begin
      set_op(3'($urandom_range(0, 7)), $urandom, $urandom);
      tick();
      if (i > 0) chk("stream_nobubble", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_wrap", 32'(op_count), 32'd1);

    // Random traffic on both sides
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_f      = 3'($urandom_range(0, 7));
      in_a      = $urandom_range(0, 3) == 0 ? in_b : $urandom;
      in_b      = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      tick();
    end
    tick();
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
